// File: rtl/uart_rx_pkg.sv
// Shared constants, state encoding and vote helper for the UART receive path.
package uart_rx_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_PRESC_W    = 6;

    // Early and late sample points sit this many CLK cycles either side of mid-bit.
    localparam int SAMPLE_OFFSET  = 1;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_START  = 3'd1;
    localparam state_t ST_DATA   = 3'd2;
    localparam state_t ST_PARITY = 3'd3;
    localparam state_t ST_STOP   = 3'd4;

    function automatic logic majority3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

endpackage

// File: rtl/uart_rx_bit_sampler.sv
// Per-bit timing: edge counter, three-point capture around mid-bit and majority vote.
module uart_rx_bit_sampler
    import uart_rx_pkg::*;
#(
    parameter int PRESC_W = DEF_PRESC_W
)
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               active_i,
    input  logic [PRESC_W-1:0] prescale_i,
    input  logic               rx_i,
    output logic               rxBit_o,
    output logic               endOfBit_o
);

    logic [PRESC_W-1:0] edgeCnt_q, edgeCnt_d;
    logic [2:0]         samples_q, samples_d;
    logic [PRESC_W-1:0] midPoint;
    logic [PRESC_W-1:0] lastEdge;

    assign midPoint   = prescale_i >> 1;
    assign lastEdge   = prescale_i - PRESC_W'(1);
    assign endOfBit_o = active_i && (edgeCnt_q == lastEdge);
    assign rxBit_o    = majority3(samples_q);

    always_comb begin
        edgeCnt_d = edgeCnt_q;
        samples_d = samples_q;
        if (!active_i) begin
            edgeCnt_d = '0;
        end else begin
            edgeCnt_d = endOfBit_o ? '0 : edgeCnt_q + PRESC_W'(1);
            if (edgeCnt_q == midPoint - PRESC_W'(SAMPLE_OFFSET)) samples_d[0] = rx_i;
            if (edgeCnt_q == midPoint)                           samples_d[1] = rx_i;
            if (edgeCnt_q == midPoint + PRESC_W'(SAMPLE_OFFSET)) samples_d[2] = rx_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            edgeCnt_q <= '0;
            samples_q <= 3'b111;
        end else begin
            edgeCnt_q <= edgeCnt_d;
            samples_q <= samples_d;
        end
    end

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: frame FSM, LSB-first shift register, parity and stop checks.
module uart_rx_top
    import uart_rx_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int PRESC_W    = DEF_PRESC_W
)
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [PRESC_W-1:0]    PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR
);

    localparam int BIT_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                 state_q, state_d;
    logic [BIT_CNT_W-1:0]   bitCnt_q, bitCnt_d;
    logic [PRESC_W-1:0]     prescale_q, prescale_d;
    logic                   parEn_q, parEn_d;
    logic                   parTyp_q, parTyp_d;
    logic [DATA_WIDTH-1:0]  shift_q, shift_d;
    logic                   parFail_q, parFail_d;
    logic [DATA_WIDTH-1:0]  pData_q, pData_d;
    logic                   dataValid_q, dataValid_d;
    logic                   parErr_q, parErr_d;
    logic                   stpErr_q, stpErr_d;

    logic                   rxBit;
    logic                   endOfBit;

    uart_rx_bit_sampler #(
        .PRESC_W (PRESC_W)
    ) u_sampler (
        .clk_i      (CLK),
        .rst_ni     (RST),
        .active_i   (state_q != ST_IDLE),
        .prescale_i (prescale_q),
        .rx_i       (RX_IN),
        .rxBit_o    (rxBit),
        .endOfBit_o (endOfBit)
    );

    always_comb begin
        state_d     = state_q;
        bitCnt_d    = bitCnt_q;
        prescale_d  = prescale_q;
        parEn_d     = parEn_q;
        parTyp_d    = parTyp_q;
        shift_d     = shift_q;
        parFail_d   = parFail_q;
        pData_d     = pData_q;
        dataValid_d = 1'b0;
        parErr_d    = 1'b0;
        stpErr_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!RX_IN) begin
                    state_d    = ST_START;
                    bitCnt_d   = '0;
                    parFail_d  = 1'b0;
                    prescale_d = PRESCALE;
                    parEn_d    = PAR_EN;
                    parTyp_d   = PAR_TYP;
                end
            end
            ST_START: begin
                if (endOfBit) state_d = rxBit ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                if (endOfBit) begin
                    shift_d = {rxBit, shift_q[DATA_WIDTH-1:1]};
                    if (bitCnt_q == BIT_CNT_W'(DATA_WIDTH - 1)) begin
                        state_d = parEn_q ? ST_PARITY : ST_STOP;
                    end else begin
                        bitCnt_d = bitCnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (endOfBit) begin
                    parFail_d = rxBit != ((^shift_q) ^ parTyp_q);
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                // Errors are reported together; only a clean frame reaches P_DATA.
                if (endOfBit) begin
                    state_d  = ST_IDLE;
                    stpErr_d = !rxBit;
                    parErr_d = parFail_q;
                    if (rxBit && !parFail_q) begin
                        dataValid_d = 1'b1;
                        pData_d     = shift_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            bitCnt_q    <= '0;
            prescale_q  <= '0;
            parEn_q     <= 1'b0;
            parTyp_q    <= 1'b0;
            shift_q     <= '0;
            parFail_q   <= 1'b0;
            pData_q     <= '0;
            dataValid_q <= 1'b0;
            parErr_q    <= 1'b0;
            stpErr_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bitCnt_q    <= bitCnt_d;
            prescale_q  <= prescale_d;
            parEn_q     <= parEn_d;
            parTyp_q    <= parTyp_d;
            shift_q     <= shift_d;
            parFail_q   <= parFail_d;
            pData_q     <= pData_d;
            dataValid_q <= dataValid_d;
            parErr_q    <= parErr_d;
            stpErr_q    <= stpErr_d;
        end
    end

    assign P_DATA     = pData_q;
    assign DATA_VALID = dataValid_q;
    assign PAR_ERR    = parErr_q;
    assign STP_ERR    = stpErr_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: frames are driven bit by bit and a scoreboard checks each strobe.
module tb_uart_rx_top;

    logic       CLK = 1'b0;
    logic       RST;
    logic       RX_IN;
    logic [5:0] PRESCALE;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       DATA_VALID;
    logic       PAR_ERR;
    logic       STP_ERR;

    typedef struct {
        logic       dv;
        logic       pe;
        logic       se;
        logic [7:0] data;
        int         startCycle;
        int         latency;
    } exp_t;

    exp_t       expQ[$];
    int         checks = 0;
    int         errors = 0;
    int         cycleCount = 0;
    logic [7:0] lastGood = 8'h00;
    logic       prevStrobe = 1'b0;

    uart_rx_top dut (
        .CLK        (CLK),
        .RST        (RST),
        .RX_IN      (RX_IN),
        .PRESCALE   (PRESCALE),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .DATA_VALID (DATA_VALID),
        .PAR_ERR    (PAR_ERR),
        .STP_ERR    (STP_ERR)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cycleCount++;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Every strobe pops the oldest expected frame; strobes must last one cycle only.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            if (prevStrobe) checkOutput("oneCycle", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'd0);
            if (DATA_VALID || PAR_ERR || STP_ERR) begin
                if (expQ.size() == 0) begin
                    checkOutput("spurious", 32'({DATA_VALID, PAR_ERR, STP_ERR}), 32'd0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("DATA_VALID", 32'(DATA_VALID), 32'(e.dv));
                    checkOutput("PAR_ERR", 32'(PAR_ERR), 32'(e.pe));
                    checkOutput("STP_ERR", 32'(STP_ERR), 32'(e.se));
                    checkOutput("P_DATA", 32'(P_DATA), 32'(e.data));
                    checkOutput("latency", 32'(cycleCount - e.startCycle + 1), 32'(e.latency));
                end
            end
            prevStrobe = DATA_VALID || PAR_ERR || STP_ERR;
        end else begin
            prevStrobe = 1'b0;
        end
    end

    task automatic driveBit(input logic v, input int p, input int spikeAt);
        for (int c = 0; c < p; c++) begin
            RX_IN = (c == spikeAt) ? ~v : v;
            @(negedge CLK);
        end
    endtask

    task automatic idleCycles(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    // Drives one frame starting at a negedge and pushes its expected outcome.
    task automatic applyStimulus(input logic [7:0] data, input int p, input logic parEn,
                                 input logic parTyp, input logic parFlip, input logic stopVal,
                                 input logic spike, input logic backToBack);
        exp_t e;
        logic parBit;
        PRESCALE = 6'(p);
        PAR_EN   = parEn;
        PAR_TYP  = parTyp;
        parBit   = (^data) ^ parTyp ^ parFlip;
        e.pe     = parEn & parFlip;
        e.se     = ~stopVal;
        e.dv     = ~e.pe & ~e.se;
        if (e.dv) lastGood = data;
        e.data       = lastGood;
        e.startCycle = cycleCount + 1 + (backToBack ? 1 : 0);
        e.latency    = 1 + (parEn ? 11 : 10) * p;
        expQ.push_back(e);

        driveBit(1'b0, p, -1);
        PRESCALE = 6'd6;
        PAR_EN   = ~parEn;
        PAR_TYP  = ~parTyp;
        for (int i = 0; i < 8; i++) begin
            driveBit(data[i], p, spike ? (p / 2 + (i % 3)) : -1);
        end
        if (parEn) driveBit(parBit, p, -1);
        driveBit(stopVal, p, -1);
        RX_IN = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        RST      = 1'b0;
        RX_IN    = 1'b1;
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        repeat (3) @(negedge CLK);
        checkOutput("resetPData", 32'(P_DATA), 32'd0);
        checkOutput("resetValid", 32'(DATA_VALID), 32'd0);
        checkOutput("resetParErr", 32'(PAR_ERR), 32'd0);
        checkOutput("resetStpErr", 32'(STP_ERR), 32'd0);
        RST = 1'b1;
        idleCycles(5);

        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(20);

        applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(20);
        applyStimulus(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        idleCycles(20);

        applyStimulus(8'hFF, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        idleCycles(40);

        // Three-cycle glitch at P=16 must be rejected within one bit period.
        PRESCALE = 6'd16;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        @(negedge CLK);
        checkOutput("glitchStart", 32'(dut.state_q), 32'd1);
        repeat (2) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (14) @(negedge CLK);
        checkOutput("glitchIdle", 32'(dut.state_q), 32'd0);
        idleCycles(5);
        applyStimulus(8'h5A, 16, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(20);

        applyStimulus(8'h96, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        idleCycles(20);

        applyStimulus(8'h01, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(8'h80, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        idleCycles(5);

        // Third frame is cut short by reset; nothing of it may survive.
        PRESCALE = 6'd8;
        PAR_EN   = 1'b0;
        driveBit(1'b0, 8, -1);
        driveBit(1'b1, 16, -1);
        RST = 1'b0;
        #1;
        checkOutput("rstPData", 32'(P_DATA), 32'd0);
        checkOutput("rstValid", 32'(DATA_VALID), 32'd0);
        checkOutput("rstParErr", 32'(PAR_ERR), 32'd0);
        checkOutput("rstStpErr", 32'(STP_ERR), 32'd0);
        checkOutput("rstState", 32'(dut.state_q), 32'd0);
        lastGood = 8'h00;
        RX_IN    = 1'b1;
        @(negedge CLK);
        RST = 1'b1;
        idleCycles(10);
        checkOutput("afterRstPData", 32'(P_DATA), 32'd0);

        applyStimulus(8'hC3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idleCycles(20);
        checkOutput("pending", 32'(expQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_top.md
# uart_rx_top

Receive-side counterpart of the UART transmit path. Recovers asynchronous serial frames (start, 8 data bits LSB-first, optional parity, one stop bit) from RX_IN using a configurable oversampling prescale, majority-votes each bit at mid-period, checks parity and stop bit, and presents the byte as P_DATA with a one-cycle DATA_VALID strobe. It sits between the RX pad synchronizer and the system data-sync / register-file logic.

## Interface
- DATA_WIDTH, 8, data bits per frame
- PRESC_W, 6, width of PRESCALE input
- CLK  input  1  oversampling clock; all logic on rising edge
- RST  input  1  asynchronous, active-low reset
- RX_IN  input  1  serial line, idle high; synchronous to CLK, with the 2-flop synchronizer upstream
- PRESCALE  input  PRESC_W  CLK cycles per bit; even values 6..32 legal; 8/16/32 verified
- PAR_EN  input  1  1 = parity bit present
- PAR_TYP  input  1  0 = even, 1 = odd
- P_DATA  output  DATA_WIDTH  last good byte
- DATA_VALID  output  1  one-cycle strobe, good frame received
- PAR_ERR  output  1  one-cycle strobe, parity mismatch
- STP_ERR  output  1  one-cycle strobe, stop bit sampled 0

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: RX_IN==0 sampled -> START; edge_cnt=0, bit_cnt=0. PRESCALE, PAR_EN, PAR_TYP captured at this transition; changes mid-frame are ignored.
- edge_cnt counts 0..PRESCALE-1 in every non-IDLE state, wraps to 0 at end of each bit.
- Sampling: RX_IN captured at edge_cnt = P/2-1, P/2, P/2+1 (P = captured prescale); bit value = majority of 3, valid from edge_cnt = P/2+2.
- START: at end of bit, voted value 1 -> glitch, return to IDLE, no outputs asserted; else -> DATA.
- DATA: voted bit shifted in LSB-first; after bit_cnt reaches DATA_WIDTH-1 end-of-bit -> PARITY if PAR_EN else STOP.
- PARITY: expected = XOR of data bits (XNOR for odd); mismatch recorded as par_fail.
- STOP: at end of bit -> IDLE. Voted 0 -> STP_ERR. par_fail -> PAR_ERR. Both may fire together. Neither -> P_DATA updated and DATA_VALID.
- Erroneous frames never update P_DATA.

## Timing
- Reset: state IDLE, counters 0, P_DATA = 0, DATA_VALID/PAR_ERR/STP_ERR = 0.
- START occupies exactly P cycles after the IDLE detection edge; each bit P cycles.
- DATA_VALID/PAR_ERR/STP_ERR registered, high for exactly one cycle, the first cycle back in IDLE: 1 + (10 or 11)*P cycles after RX_IN low is first sampled in IDLE.
- P_DATA changes in the same cycle DATA_VALID rises and holds until the next good frame.
- Back-to-back frames: a start bit low in the first IDLE cycle is detected there; no idle gap required.
- Glitch shorter than P/2-1 cycles: no strobe, FSM in IDLE by end of start-bit period.
- RST asserted mid-frame: immediate return to reset values; partial byte discarded.

## Structure
- Package uart_rx_pkg: state enum, DATA_WIDTH and PRESC_W defaults, sample-point offsets.
- Sub-module uart_rx_bit_sampler: edge counter, 3-point capture, majority vote, end-of-bit flag. FSM, shift register, parity and stop checks stay in top.

## Test plan
- P=8, PAR_EN=0, byte 0xA5 -> DATA_VALID one cycle at 1+10*8=81 cycles after start, P_DATA=0xA5, no errors.
- P=16, PAR_EN=1, PAR_TYP=0, 0x3C with parity 0 -> DATA_VALID at 177; same byte with parity 1 -> PAR_ERR only, P_DATA unchanged.
- P=32, odd parity, 0xFF with stop bit forced 0 -> STP_ERR one cycle; no DATA_VALID.
- RX_IN low for 3 cycles at P=16 -> no strobe, state IDLE after 16 cycles; following real frame 0x5A received correctly.
- Single-cycle spike inverting one sample point per data bit at P=8 -> majority vote yields 0x96 unchanged.
- Two back-to-back frames 0x01, 0x80 with zero idle gap; RST pulsed mid-third frame -> two DATA_VALIDs, then all outputs 0, P_DATA=0.
